// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, issues fetches to a variable-latency imem, and hands the word to IF/ID.
// Optional fetch timeout with sticky error state is enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] next_pc,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        if_en,
    output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, READY = 2'd2, ERR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, READY = 2'd2} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
`ifdef FETCH_TIMEOUT_EN
    logic [15:0] cnt_q;
`endif

    // PC only advances when IF/ID consumes the word, so a D-stage redirect is sampled exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= 16'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
`ifdef FETCH_TIMEOUT_EN
                    cnt_q   <= 16'h0;
`endif
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= READY;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (cnt_q == 16'(TIMEOUT)) begin
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 16'h1;
                    end
`endif
                end
                READY: begin
                    if (!stall) begin
                        pc_q    <= next_pc;
                        state_q <= FETCH;
`ifdef FETCH_TIMEOUT_EN
                        cnt_q   <= 16'h0;
`endif
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ERR: begin
                    state_q <= ERR;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PC        = pc_q;
    assign PC4       = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == FETCH);
    assign if_en     = (state_q == READY) && !stall;
    assign instr_out = instr_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = (state_q == ERR);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (default build): reset, zero-wait and multi-cycle fetches,
// stalls, delay-slot redirect, reset during an outstanding fetch, and PC4 wrap.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] next_pc;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        if_en;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .next_pc   (next_pc),
        .PC        (PC),
        .PC4       (PC4),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .instr_out (instr_out),
        .if_en     (if_en),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        next_pc    = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        applyStimulus();

        checkOutput("rst_pc", PC, 32'h0000_3000);
        checkOutput("rst_pc4", PC4, 32'h0000_3004);
        checkOutput("rst_req", 32'(imem_req), 32'h0);
        checkOutput("rst_ifen", 32'(if_en), 32'h0);
        checkOutput("rst_instr", instr_out, 32'h0);
        checkOutput("rst_err", 32'(fetch_err), 32'h0);

        reset = 1'b0;
        #1;
        checkOutput("idle_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        applyStimulus();
        checkOutput("first_req", 32'(imem_req), 32'h1);
        checkOutput("first_addr", imem_addr, 32'h0000_3000);

        // Zero-wait memory
        imem_ack   = 1'b1;
        imem_rdata = 32'h2408_0001;
        next_pc    = 32'h0000_3004;
        applyStimulus();
        imem_ack = 1'b0;
        checkOutput("zw0_ifen", 32'(if_en), 32'h1);
        checkOutput("zw0_instr", instr_out, 32'h2408_0001);
        checkOutput("zw0_req", 32'(imem_req), 32'h0);
        checkOutput("zw0_pc", PC, 32'h0000_3000);
        applyStimulus();
        checkOutput("zw1_req", 32'(imem_req), 32'h1);
        checkOutput("zw1_addr", imem_addr, 32'h0000_3004);
        checkOutput("zw1_ifen", 32'(if_en), 32'h0);
        imem_ack = 1'b1;
        next_pc  = 32'h0000_3008;
        applyStimulus();
        imem_ack = 1'b0;
        checkOutput("zw2_ifen", 32'(if_en), 32'h1);
        applyStimulus();
        checkOutput("zw3_pc", PC, 32'h0000_3008);
        checkOutput("zw3_req", 32'(imem_req), 32'h1);

        // Three-cycle latency: two waiting cycles, ack on the third
        applyStimulus();
        checkOutput("lat1_req", 32'(imem_req), 32'h1);
        checkOutput("lat1_addr", imem_addr, 32'h0000_3008);
        checkOutput("lat1_instr", instr_out, 32'h2408_0001);
        applyStimulus();
        checkOutput("lat2_req", 32'(imem_req), 32'h1);
        checkOutput("lat2_addr", imem_addr, 32'h0000_3008);
        checkOutput("lat2_instr", instr_out, 32'h2408_0001);
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C09_0004;
        applyStimulus();
        imem_ack = 1'b0;
        checkOutput("lat3_instr", instr_out, 32'h8C09_0004);
        checkOutput("lat3_req", 32'(imem_req), 32'h0);

        // Stall held for four cycles in READY; a stray ack must be ignored
        stall   = 1'b1;
        next_pc = 32'h0000_3040;
        #1;
        checkOutput("stl_ifen0", 32'(if_en), 32'h0);
        for (int i = 0; i < 4; i++) begin
            imem_ack   = (i == 1);
            imem_rdata = 32'hDEAD_BEEF;
            applyStimulus();
            imem_ack = 1'b0;
            checkOutput($sformatf("stl%0d_pc", i), PC, 32'h0000_3008);
            checkOutput($sformatf("stl%0d_ifen", i), 32'(if_en), 32'h0);
            checkOutput($sformatf("stl%0d_instr", i), instr_out, 32'h8C09_0004);
        end
        stall = 1'b0;
        #1;
        checkOutput("rel_ifen", 32'(if_en), 32'h1);
        applyStimulus();
        checkOutput("rel_pc", PC, 32'h0000_3040);
        checkOutput("rel_req", 32'(imem_req), 32'h1);

        // Reset while waiting, with an ack in the reset cycle
        applyStimulus();
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        reset      = 1'b1;
        #1;
        checkOutput("mrst_pc", PC, 32'h0000_3000);
        checkOutput("mrst_req", 32'(imem_req), 32'h0);
        applyStimulus();
        checkOutput("mrst_instr", instr_out, 32'h0);
        checkOutput("mrst_pc2", PC, 32'h0000_3000);
        imem_ack = 1'b0;
        reset    = 1'b0;
        applyStimulus();

        // Branch at 0x3000, delay slot at 0x3004, target 0x3100
        checkOutput("br0_addr", imem_addr, 32'h0000_3000);
        checkOutput("br0_req", 32'(imem_req), 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1000_003F;
        next_pc    = 32'h0000_3004;
        applyStimulus();
        imem_ack = 1'b0;
        applyStimulus();
        checkOutput("br1_addr", imem_addr, 32'h0000_3004);
        applyStimulus();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0000;
        next_pc    = 32'h0000_3100;
        applyStimulus();
        imem_ack = 1'b0;
        checkOutput("br1_ifen", 32'(if_en), 32'h1);
        applyStimulus();
        checkOutput("br2_addr", imem_addr, 32'h0000_3100);
        checkOutput("br2_pc4", PC4, 32'h0000_3104);

        // Unaligned next_pc loaded as-is, PC4 wraps
        imem_ack   = 1'b1;
        imem_rdata = 32'h0123_4567;
        next_pc    = 32'hFFFF_FFFE;
        applyStimulus();
        imem_ack = 1'b0;
        checkOutput("wrap_instr", instr_out, 32'h0123_4567);
        applyStimulus();
        checkOutput("wrap_pc", PC, 32'hFFFF_FFFE);
        checkOutput("wrap_pc4", PC4, 32'h0000_0002);
        checkOutput("wrap_err", 32'(fetch_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
